watch_readback: RTL and testbench

- Reader for the watch display path: samples the four 7-segment digit buses and decodes them back to digits.
- Packs the result into the same 12-bit time word format used to load the watch, and returns it through a req/valid handshake.
- Sits beside the hh:mm display logic on the crystal-derived clock and feeds the SoC readback register.
- The counters ripple through divided clocks, so a read is only accepted after several identical consecutive samples (tear-free snapshot).

---
 rtl/watch_readback_pkg.sv | 47 ++++
 rtl/watch_readback_seg7_to_bcd.sv | 30 +++
 rtl/watch_readback.sv | 152 +++++++++++++++
 tb/tb_watch_readback.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/watch_readback_pkg.sv
// Shared definitions for the watch readback path: segment codes, error codes,
// FSM encoding and the time-word field layout used to load/read the watch.
package watch_readback_pkg;

  // 7-segment codes {g,f,e,d,c,b,a}, active high, for digits 0-9
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;

  // Readback status codes
  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL = 2'd1;
  localparam logic [1:0] ERR_RANGE   = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  // Time-word field positions
  localparam int MU_LSB = 0;
  localparam int MT_LSB = 4;
  localparam int HH_LSB = 7;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPARE = 2'd1,
    ST_DECODE  = 2'd2,
    ST_DONE    = 2'd3
  } rb_state_e;

  // Pack hours / minute tens / minute units into the 12-bit time word
  function automatic logic [11:0] pack_time(input logic [4:0] hours,
                                            input logic [2:0] mt,
                                            input logic [3:0] mu);
    logic [11:0] word;
    word = 12'd0;
    word[HH_LSB +: 5] = hours;
    word[MT_LSB +: 3] = mt;
    word[MU_LSB +: 4] = mu;
    return word;
  endfunction

endpackage

// File: rtl/watch_readback_seg7_to_bcd.sv
// Inverse of the digit encoder: 7-segment pattern back to a BCD digit.
// Any pattern that the encoder never produces is flagged as not legal.
module seg7_to_bcd
  import watch_readback_pkg::*;
(
  input  logic [6:0] segment,
  output logic [3:0] digit,
  output logic       legal
);

  // Look up the pattern; unknown patterns give digit 0 and legal=0
  always_comb begin
    digit = 4'd0;
    legal = 1'b1;
    case (segment)
      SEG_0:   digit = 4'd0;
      SEG_1:   digit = 4'd1;
      SEG_2:   digit = 4'd2;
      SEG_3:   digit = 4'd3;
      SEG_4:   digit = 4'd4;
      SEG_5:   digit = 4'd5;
      SEG_6:   digit = 4'd6;
      SEG_7:   digit = 4'd7;
      SEG_8:   digit = 4'd8;
      SEG_9:   digit = 4'd9;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/watch_readback.sv
// Watch display readback: waits for a tear-free snapshot of the four digit
// buses (the counters ripple through divided clocks), decodes it back to the
// 12-bit time word and returns it with a status code on a req/valid handshake.
module watch_readback
  import watch_readback_pkg::*;
#(
  parameter int STABLE_CYCLES = 2,
  parameter int MAX_TRIES     = 8
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        rd_req_i,
  input  logic [6:0]  segment_hxxx_i,
  input  logic [6:0]  segment_xhxx_i,
  input  logic [6:0]  segment_xxmx_i,
  input  logic [6:0]  segment_xxxm_i,
  output logic        busy_o,
  output logic        rvalid_o,
  output logic [11:0] rdata_o,
  output logic [1:0]  err_o
);

  localparam int MW = $clog2(STABLE_CYCLES + 1);
  localparam int TW = $clog2(MAX_TRIES + 1);

  rb_state_e   state_r, state_next_s;
  logic [27:0] seg_all_s, snap_r, snap_next_s;
  logic [MW-1:0] match_r, match_next_s, match_inc_s;
  logic [TW-1:0] tries_r, tries_next_s, tries_inc_s;
  logic        busy_next_s, rvalid_next_s;
  logic [11:0] rdata_next_s, decode_word_s;
  logic [1:0]  err_next_s, decode_err_s;
  logic [3:0]  ht_s, hu_s, mt_s, mu_s;
  logic        ht_ok_s, hu_ok_s, mt_ok_s, mu_ok_s;
  logic [6:0]  hours_wide_s;

  assign seg_all_s = {segment_hxxx_i, segment_xhxx_i, segment_xxmx_i, segment_xxxm_i};

  // Decoding always works on the stable snapshot, never on the live buses
  seg7_to_bcd u_dec_ht (.segment(snap_r[27:21]), .digit(ht_s), .legal(ht_ok_s));
  seg7_to_bcd u_dec_hu (.segment(snap_r[20:14]), .digit(hu_s), .legal(hu_ok_s));
  seg7_to_bcd u_dec_mt (.segment(snap_r[13:7]),  .digit(mt_s), .legal(mt_ok_s));
  seg7_to_bcd u_dec_mu (.segment(snap_r[6:0]),   .digit(mu_s), .legal(mu_ok_s));

  // Classify the snapshot: illegal pattern beats out-of-range value
  always_comb begin
    hours_wide_s = 7'(ht_s) * 7'd10 + 7'(hu_s);
    if (!(ht_ok_s && hu_ok_s && mt_ok_s && mu_ok_s)) begin
      decode_err_s  = ERR_ILLEGAL;
      decode_word_s = 12'd0;
    end else if ((mt_s > 4'd5) || (ht_s > 4'd2) || (hours_wide_s > 7'd23)) begin
      decode_err_s  = ERR_RANGE;
      decode_word_s = 12'd0;
    end else begin
      decode_err_s  = ERR_OK;
      decode_word_s = pack_time(hours_wide_s[4:0], mt_s[2:0], mu_s);
    end
  end

  // Next-state and next-output logic for the snapshot FSM
  always_comb begin
    state_next_s  = state_r;
    snap_next_s   = snap_r;
    match_next_s  = match_r;
    tries_next_s  = tries_r;
    busy_next_s   = busy_o;
    rvalid_next_s = 1'b0;
    rdata_next_s  = rdata_o;
    err_next_s    = err_o;
    match_inc_s   = match_r + MW'(1);
    tries_inc_s   = tries_r + TW'(1);
    case (state_r)
      ST_IDLE, ST_DONE: begin
        busy_next_s = 1'b0;
        if (rd_req_i) begin
          state_next_s = ST_COMPARE;
          snap_next_s  = seg_all_s;
          match_next_s = MW'(1);
          tries_next_s = TW'(0);
          busy_next_s  = 1'b1;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_COMPARE: begin
        if (seg_all_s == snap_r) begin
          match_next_s = match_inc_s;
          if (match_inc_s == MW'(STABLE_CYCLES)) begin
            state_next_s = ST_DECODE;
          end else begin
            state_next_s = ST_COMPARE;
          end
        end else begin
          snap_next_s  = seg_all_s;
          match_next_s = MW'(1);
          tries_next_s = tries_inc_s;
          if (tries_inc_s == TW'(MAX_TRIES)) begin
            state_next_s  = ST_DONE;
            busy_next_s   = 1'b0;
            rvalid_next_s = 1'b1;
            rdata_next_s  = 12'd0;
            err_next_s    = ERR_TIMEOUT;
          end else begin
            state_next_s = ST_COMPARE;
          end
        end
      end
      ST_DECODE: begin
        state_next_s  = ST_DONE;
        busy_next_s   = 1'b0;
        rvalid_next_s = 1'b1;
        rdata_next_s  = decode_word_s;
        err_next_s    = decode_err_s;
      end
      default: begin
        state_next_s = ST_IDLE;
        busy_next_s  = 1'b0;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Snapshot/counter registers and registered outputs
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      snap_r   <= 28'd0;
      match_r  <= MW'(0);
      tries_r  <= TW'(0);
      busy_o   <= 1'b0;
      rvalid_o <= 1'b0;
      rdata_o  <= 12'd0;
      err_o    <= ERR_OK;
    end else begin
      snap_r   <= snap_next_s;
      match_r  <= match_next_s;
      tries_r  <= tries_next_s;
      busy_o   <= busy_next_s;
      rvalid_o <= rvalid_next_s;
      rdata_o  <= rdata_next_s;
      err_o    <= err_next_s;
    end
  end

endmodule

// File: tb/tb_watch_readback.sv
// Self-checking bench for watch_readback: directed and randomized reads
// against a reference model built from the snapshot/decode rules.
module tb_watch_readback;

  localparam int STABLE = 2;
  localparam int TRIES  = 8;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        rd_req_i;
  logic [6:0]  segment_hxxx_i, segment_xhxx_i, segment_xxmx_i, segment_xxxm_i;
  logic        busy_o, rvalid_o;
  logic [11:0] rdata_o;
  logic [1:0]  err_o;

  int errors = 0;
  int checks = 0;

  logic [6:0]  code_tab [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                  7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  logic [27:0] plan [0:31];
  int          plan_len;

  watch_readback #(.STABLE_CYCLES(STABLE), .MAX_TRIES(TRIES)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .rd_req_i(rd_req_i),
    .segment_hxxx_i(segment_hxxx_i), .segment_xhxx_i(segment_xhxx_i),
    .segment_xxmx_i(segment_xxmx_i), .segment_xxxm_i(segment_xxxm_i),
    .busy_o(busy_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  // Digit value of a segment code, -1 if the code is not a digit
  function automatic int seg_digit(input logic [6:0] c);
    for (int k = 0; k < 10; k++) if (code_tab[k] == c) return k;
    return -1;
  endfunction

  function automatic logic [27:0] disp(input int a, input int b, input int c, input int d);
    return {code_tab[a], code_tab[b], code_tab[c], code_tab[d]};
  endfunction

  // Expected {err, rdata} for a settled display
  function automatic logic [13:0] expect_word(input logic [27:0] s);
    int d [4];
    int hours;
    for (int k = 0; k < 4; k++) d[k] = seg_digit(s[k*7 +: 7]);
    if (d[0] < 0 || d[1] < 0 || d[2] < 0 || d[3] < 0) return {2'd1, 12'd0};
    hours = d[3] * 10 + d[2];
    if (d[1] > 5 || d[3] > 2 || hours > 23) return {2'd2, 12'd0};
    return {2'd0, 12'(hours * 128 + d[1] * 16 + d[0])};
  endfunction

  function automatic logic [27:0] sample(input int i);
    if (i < plan_len) return plan[i];
    return plan[plan_len-1];
  endfunction

  task automatic set_inputs(input logic [27:0] v);
    {segment_hxxx_i, segment_xhxx_i, segment_xxmx_i, segment_xxxm_i} = v;
  endtask

  // One read: plan[i] is the display seen at edge i (edge 0 accepts).
  task automatic run_read(input string tag, input bit pulse_busy);
    int          done_edge = -1;
    int          streak = 1;
    int          trans = 0;
    logic [13:0] expw = 14'd0;
    for (int i = 1; i < 48 && done_edge < 0; i++) begin
      if (sample(i) == sample(i-1)) begin
        streak++;
        if (streak == STABLE) begin
          done_edge = i + 1;
          expw = expect_word(sample(i));
        end
      end else begin
        streak = 1;
        trans++;
        if (trans == TRIES) begin
          done_edge = i;
          expw = {2'd3, 12'd0};
        end
      end
    end
    for (int i = 0; i <= done_edge; i++) begin
      set_inputs(sample(i));
      rd_req_i = (i == 0) || (pulse_busy && i == 1);
      tick();
      if (i < done_edge) begin
        check({tag, ".rvalid_wait"}, 32'(rvalid_o), 32'd0);
        check({tag, ".busy_wait"}, 32'(busy_o), 32'd1);
      end else begin
        check({tag, ".rvalid"}, 32'(rvalid_o), 32'd1);
        check({tag, ".busy_done"}, 32'(busy_o), 32'd0);
        check({tag, ".rdata"}, 32'(rdata_o), 32'(expw[11:0]));
        check({tag, ".err"}, 32'(err_o), 32'(expw[13:12]));
      end
    end
    rd_req_i = 1'b0;
    tick();
    check({tag, ".rvalid_after"}, 32'(rvalid_o), 32'd0);
    check({tag, ".busy_after"}, 32'(busy_o), 32'd0);
    check({tag, ".rdata_hold"}, 32'(rdata_o), 32'(expw[11:0]));
    check({tag, ".err_hold"}, 32'(err_o), 32'(expw[13:12]));
  endtask

  initial begin
    rstn_i   = 1'b0;
    rd_req_i = 1'b0;
    set_inputs(28'd0);
    #12;
    check("reset.busy", 32'(busy_o), 32'd0);
    check("reset.rvalid", 32'(rvalid_o), 32'd0);
    check("reset.rdata", 32'(rdata_o), 32'd0);
    check("reset.err", 32'(err_o), 32'd0);
    @(posedge clk_i);
    #1;
    rstn_i = 1'b1;
    tick();

    // 13:45 with a request pulse while busy that must be ignored
    plan[0] = disp(1, 3, 4, 5); plan_len = 1;
    run_read("t1345", 1'b1);
    check("t1345.const", 32'(rdata_o), 32'h6C5);

    plan[0] = disp(2, 3, 5, 9); plan_len = 1;
    run_read("t2359", 1'b0);
    check("t2359.const", 32'(rdata_o), 32'hBD9);

    // minute units settles 9->0 mid-read
    plan[0] = disp(2, 3, 5, 9); plan[1] = disp(2, 3, 5, 0); plan_len = 2;
    run_read("change", 1'b0);
    check("change.const", 32'(rdata_o), 32'hBD0);

    // one-cycle glitch on minute units before settling to 0
    plan[0] = disp(2, 3, 5, 9); plan[1] = disp(2, 3, 5, 8); plan[2] = disp(2, 3, 5, 0);
    plan_len = 3;
    run_read("glitch", 1'b0);

    plan[0] = {7'h00, code_tab[3], code_tab[4], code_tab[5]}; plan_len = 1;
    run_read("illegal", 1'b0);
    check("illegal.const", 32'(err_o), 32'd1);

    plan[0] = disp(2, 4, 0, 0); plan_len = 1;
    run_read("hours24", 1'b0);
    check("hours24.const", 32'(err_o), 32'd2);

    plan[0] = disp(1, 2, 6, 0); plan_len = 1;
    run_read("mt6", 1'b0);

    // minute units toggling every cycle -> timeout
    for (int i = 0; i < 20; i++) plan[i] = disp(1, 2, 3, (i % 2 == 0) ? 4 : 5);
    plan_len = 20;
    run_read("timeout", 1'b0);
    check("timeout.const", 32'(err_o), 32'd3);

    // held request: a completion every third cycle
    set_inputs(disp(0, 0, 0, 0));
    rd_req_i = 1'b1;
    for (int k = 0; k < 9; k++) begin
      tick();
      check("held.rvalid", 32'(rvalid_o), 32'(k % 3 == 2));
      check("held.busy", 32'(busy_o), 32'(k % 3 != 2));
      if (k % 3 == 2) begin
        check("held.rdata", 32'(rdata_o), 32'd0);
        check("held.err", 32'(err_o), 32'd0);
      end
    end
    rd_req_i = 1'b0;
    tick();
    check("held.stop", 32'(rvalid_o), 32'd0);

    // leave nonzero data, then reset mid-COMPARE
    plan[0] = disp(0, 9, 5, 7); plan_len = 1;
    run_read("t0957", 1'b0);
    set_inputs(disp(1, 1, 1, 1));
    rd_req_i = 1'b1;
    tick();
    rd_req_i = 1'b0;
    check("rst.busy_before", 32'(busy_o), 32'd1);
    #2;
    rstn_i = 1'b0;
    #1;
    check("rst.busy", 32'(busy_o), 32'd0);
    check("rst.rvalid", 32'(rvalid_o), 32'd0);
    check("rst.rdata", 32'(rdata_o), 32'd0);
    check("rst.err", 32'(err_o), 32'd0);
    tick();
    check("rst.no_rvalid", 32'(rvalid_o), 32'd0);
    rstn_i = 1'b1;
    tick();
    check("rst.idle", 32'(rvalid_o), 32'd0);
    plan[0] = disp(1, 1, 1, 1); plan_len = 1;
    run_read("post_rst", 1'b0);

    // randomized displays, occasional illegal codes and leading glitches
    for (int r = 0; r < 24; r++) begin
      logic [27:0] settled;
      int          ng;
      settled = disp($urandom_range(0, 3), $urandom_range(0, 9),
                     $urandom_range(0, 6), $urandom_range(0, 9));
      for (int p = 0; p < 4; p++) begin
        if ($urandom_range(0, 9) == 0) settled[p*7 +: 7] = 7'($urandom_range(0, 127));
      end
      ng = $urandom_range(0, 2);
      for (int g = 0; g < ng; g++) plan[g] = 28'($urandom);
      plan[ng] = settled;
      plan_len = ng + 1;
      run_read("random", 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
